// File: rtl/fwd_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard_pkg
// Brief    : Shared hazard definitions: default sizes, stage indices and
//            Tuse/Tnew encodings per instruction class.
// Revision : 1.0 - initial release
// ============================================================================
package fwd_scoreboard_pkg;

    localparam int c_width = 32;
    localparam int c_aw    = 5;
    localparam int c_nsrc  = 2;
    localparam int c_depth = 3;
    localparam int c_tw    = 2;

    localparam int c_stage_e = 0;
    localparam int c_stage_m = 1;
    localparam int c_stage_w = 2;

    // Tnew: cycles after entering E until the result is on a stage bus.
    localparam logic [c_tw-1:0] c_tnew_link = 2'd0;
    localparam logic [c_tw-1:0] c_tnew_alu  = 2'd1;
    localparam logic [c_tw-1:0] c_tnew_load = 2'd2;

    // Tuse: cycles until an operand is consumed, counted from decode.
    localparam logic [c_tw-1:0] c_tuse_branch = 2'd0;
    localparam logic [c_tw-1:0] c_tuse_alu    = 2'd1;
    localparam logic [c_tw-1:0] c_tuse_store  = 2'd2;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_LINK   = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_STORE  = 3'd4
    } instr_cls_e;

    function automatic logic [c_tw-1:0] tnew_of(input instr_cls_e cls);
        logic [c_tw-1:0] v;
        v = c_tnew_alu;
        case (cls)
            CLS_LOAD: v = c_tnew_load;
            CLS_LINK: v = c_tnew_link;
            default:  v = c_tnew_alu;
        endcase
        return v;
    endfunction

endpackage : fwd_scoreboard_pkg
`default_nettype wire

// File: rtl/fwd_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard_if
// Brief    : Decode-side bus between the decode stage and the forwarding unit.
// Revision : 1.0 - initial release
// ============================================================================
interface fwd_scoreboard_if
    import fwd_scoreboard_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int AW    = c_aw,
    parameter int NSRC  = c_nsrc,
    parameter int DEPTH = c_depth,
    parameter int TW    = c_tw
);
    logic                   issue_valid;
    logic [AW-1:0]          issue_dst;
    logic [TW-1:0]          issue_tnew;
    logic                   flush;
    logic [NSRC*AW-1:0]     src_addr;
    logic [NSRC*TW-1:0]     src_tuse;
    logic [NSRC*WIDTH-1:0]  rf_data;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic [NSRC*WIDTH-1:0]  op_data;
    logic [NSRC-1:0]        op_pending;
    logic                   stall;
    logic [31:0]            stall_cnt;

    modport master (
        output issue_valid, issue_dst, issue_tnew, flush,
        output src_addr, src_tuse, rf_data, stage_data,
        input  op_data, op_pending, stall, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_dst, issue_tnew, flush,
        input  src_addr, src_tuse, rf_data, stage_data,
        output op_data, op_pending, stall, stall_cnt
    );

endinterface : fwd_scoreboard_if
`default_nettype wire

// File: rtl/fwd_scoreboard_match.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard_match
// Brief    : Priority compare of one source operand against the tag pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_scoreboard_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int AW    = c_aw,
    parameter int TW    = c_tw,
    parameter int DEPTH = c_depth,
    parameter int SW    = 2
) (
    input  logic [DEPTH-1:0]    i_valid,
    input  logic [DEPTH*AW-1:0] i_dst,
    input  logic [DEPTH*TW-1:0] i_tnew,
    input  logic [AW-1:0]       i_src,
    input  logic [TW-1:0]       i_tuse,
    output logic                o_hit,
    output logic [SW-1:0]       o_stage,
    output logic                o_ready,
    output logic                o_stall_req
);

    logic [TW-1:0] w_tnew_sel;

    // Walk oldest to youngest so the nearest matching stage overwrites older ones.
    always_comb begin
        o_hit      = 1'b0;
        o_stage    = '0;
        w_tnew_sel = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (i_valid[s] && (i_dst[s*AW +: AW] == i_src) && (i_src != '0)) begin
                o_hit      = 1'b1;
                o_stage    = SW'(s);
                w_tnew_sel = i_tnew[s*TW +: TW];
            end
        end
    end

    assign o_ready     = o_hit && (w_tnew_sel == '0);
    assign o_stall_req = o_hit && (w_tnew_sel > i_tuse);

endmodule : fwd_scoreboard_match
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard
// Brief    : Decode-stage forwarding/hazard unit with a DEPTH-stage tag pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int AW    = c_aw,
    parameter int NSRC  = c_nsrc,
    parameter int DEPTH = c_depth,
    parameter int TW    = c_tw
) (
    input  logic           clk,
    input  logic           rst_n,
    fwd_scoreboard_if.slave s_bus
);

    localparam int c_sw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]    r_valid;
    logic [DEPTH*AW-1:0] r_dst;
    logic [DEPTH*TW-1:0] r_tnew;
    logic [31:0]         r_stall_cnt;

    logic                w_load0;
    logic                w_stall;
    logic [NSRC-1:0]     w_hit;
    logic [NSRC-1:0]     w_ready;
    logic [NSRC-1:0]     w_stall_req;
    logic [NSRC*c_sw-1:0] w_stage;

    // A stalled or flushed decode slot enters E as a bubble; r0 writes never track.
    assign w_load0 = s_bus.issue_valid && (s_bus.issue_dst != '0) &&
                     !w_stall && !s_bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid[0]       <= 1'b0;
            r_dst[0 +: AW]   <= '0;
            r_tnew[0 +: TW]  <= '0;
        end else begin
            r_valid[0]       <= w_load0;
            r_dst[0 +: AW]   <= s_bus.issue_dst;
            r_tnew[0 +: TW]  <= w_load0 ? s_bus.issue_tnew : '0;
        end
    end

    generate
        for (genvar s = 1; s < DEPTH; s++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[s]          <= 1'b0;
                    r_dst[s*AW +: AW]   <= '0;
                    r_tnew[s*TW +: TW]  <= '0;
                end else begin
                    r_valid[s]          <= r_valid[s-1];
                    r_dst[s*AW +: AW]   <= r_dst[(s-1)*AW +: AW];
                    r_tnew[s*TW +: TW]  <= (r_tnew[(s-1)*TW +: TW] == '0) ? '0 :
                                           r_tnew[(s-1)*TW +: TW] - TW'(1);
                end
            end
        end
    endgenerate

    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src
            fwd_scoreboard_match #(
                .AW    (AW),
                .TW    (TW),
                .DEPTH (DEPTH),
                .SW    (c_sw)
            ) u_match (
                .i_valid     (r_valid),
                .i_dst       (r_dst),
                .i_tnew      (r_tnew),
                .i_src       (s_bus.src_addr[i*AW +: AW]),
                .i_tuse      (s_bus.src_tuse[i*TW +: TW]),
                .o_hit       (w_hit[i]),
                .o_stage     (w_stage[i*c_sw +: c_sw]),
                .o_ready     (w_ready[i]),
                .o_stall_req (w_stall_req[i])
            );

            // Pending producers fall back to RF data; a later stage will forward them.
            assign s_bus.op_data[i*WIDTH +: WIDTH] = (w_hit[i] && w_ready[i]) ?
                s_bus.stage_data[int'(w_stage[i*c_sw +: c_sw])*WIDTH +: WIDTH] :
                s_bus.rf_data[i*WIDTH +: WIDTH];

            assign s_bus.op_pending[i] = w_hit[i] && !w_ready[i] && !w_stall_req[i];
        end
    endgenerate

    assign w_stall     = |w_stall_req;
    assign s_bus.stall = w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign s_bus.stall_cnt = r_stall_cnt;

endmodule : fwd_scoreboard
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_scoreboard
// Brief    : Directed self-checking bench for fwd_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;
    import fwd_scoreboard_pkg::*;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int NSRC  = 2;
    localparam int DEPTH = 3;
    localparam int TW    = 2;

    localparam logic [31:0] c_rf0 = 32'hF0F0_0000;
    localparam logic [31:0] c_rf1 = 32'hF1F1_0001;
    localparam logic [31:0] c_se  = 32'h0000_5555;
    localparam logic [31:0] c_sm  = 32'h0000_3C3C;
    localparam logic [31:0] c_sw  = 32'h0000_AAAA;

    typedef struct {
        string       tag;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  pend;
        logic        stl;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fwd_scoreboard_if #(.WIDTH(WIDTH), .AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .TW(TW)) bus ();

    fwd_scoreboard #(.WIDTH(WIDTH), .AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] pend, input logic stl);
        exp_t e;
        e.tag = tag; e.d0 = d0; e.d1 = d1; e.pend = pend; e.stl = stl;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".d0"},    bus.op_data[31:0],        e.d0);
            cmp({e.tag, ".d1"},    bus.op_data[63:32],       e.d1);
            cmp({e.tag, ".pend"},  32'(bus.op_pending),      32'(e.pend));
            cmp({e.tag, ".stall"}, 32'(bus.stall),           32'(e.stl));
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] pend, input logic stl);
        push_exp(tag, d0, d1, pend, stl);
        @(negedge clk);
        pop_check();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [AW-1:0] d, input logic [TW-1:0] t);
        bus.issue_valid = v;
        bus.issue_dst   = d;
        bus.issue_tnew  = t;
    endtask

    task automatic set_src(input logic [AW-1:0] a0, input logic [TW-1:0] t0,
                           input logic [AW-1:0] a1, input logic [TW-1:0] t1);
        bus.src_addr = {a1, a0};
        bus.src_tuse = {t1, t0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        issue(1'b0, '0, '0);
        set_src('0, '0, '0, '0);
        bus.flush      = 1'b0;
        bus.rf_data    = {c_rf1, c_rf0};
        bus.stage_data = {c_sw, c_sm, c_se};

        // Reset state
        tick(); tick();
        expect_now("reset", c_rf0, c_rf1, 2'b00, 1'b0);
        cmp("reset.cnt", bus.stall_cnt, 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU -> ALU: pending in E, forwarded from M
        issue(1'b1, 5'd5, c_tnew_alu);
        expect_now("alu.issue", c_rf0, c_rf1, 2'b00, 1'b0);
        tick();
        issue(1'b0, '0, '0);
        set_src(5'd5, c_tuse_alu, '0, '0);
        expect_now("alu.e", c_rf0, c_rf1, 2'b01, 1'b0);
        tick();
        expect_now("alu.m", c_sm, c_rf1, 2'b00, 1'b0);
        cmp("alu.cnt", bus.stall_cnt, 32'd0);
        set_src('0, '0, '0, '0);
        tick(); tick(); tick();

        // Load-use: two stall cycles, then forwarded from W
        issue(1'b1, 5'd8, c_tnew_load);
        tick();
        issue(1'b0, '0, '0);
        set_src('0, '0, 5'd8, c_tuse_branch);
        expect_now("lu.e", c_rf0, c_rf1, 2'b00, 1'b1);
        tick();
        expect_now("lu.m", c_rf0, c_rf1, 2'b00, 1'b1);
        tick();
        expect_now("lu.w", c_rf0, c_sw, 2'b00, 1'b0);
        cmp("lu.cnt", bus.stall_cnt, 32'd2);
        set_src('0, '0, '0, '0);
        tick(); tick(); tick();

        // Priority: nearest producer wins, even when it is not ready
        issue(1'b1, 5'd3, c_tnew_link);
        tick();
        issue(1'b0, '0, '0);
        tick();
        issue(1'b1, 5'd3, c_tnew_link);
        tick();
        issue(1'b1, 5'd3, c_tnew_load);
        set_src(5'd3, c_tuse_alu, '0, '0);
        expect_now("prio.e", c_se, c_rf1, 2'b00, 1'b0);
        tick();
        issue(1'b0, '0, '0);
        expect_now("prio.notready", c_rf0, c_rf1, 2'b00, 1'b1);
        set_src('0, '0, '0, '0);
        tick(); tick(); tick();
        cmp("prio.cnt", bus.stall_cnt, 32'd2);

        // r0 is never tracked
        issue(1'b1, 5'd0, c_tnew_alu);
        tick();
        issue(1'b0, '0, '0);
        set_src(5'd0, c_tuse_branch, 5'd0, c_tuse_branch);
        expect_now("r0", c_rf0, c_rf1, 2'b00, 1'b0);

        // Flushed issue never becomes a producer
        issue(1'b1, 5'd7, c_tnew_link);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        issue(1'b0, '0, '0);
        set_src(5'd7, c_tuse_branch, 5'd7, c_tuse_store);
        expect_now("flush", c_rf0, c_rf1, 2'b00, 1'b0);
        set_src('0, '0, '0, '0);
        tick(); tick(); tick();

        // Counter saturation, preloaded just below the top
        issue(1'b1, 5'd9, c_tnew_load);
        tick();
        issue(1'b0, '0, '0);
        set_src(5'd9, c_tuse_branch, '0, '0);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        expect_now("sat.e", c_rf0, c_rf1, 2'b00, 1'b1);
        tick();
        cmp("sat.cnt1", bus.stall_cnt, 32'hFFFF_FFFF);
        expect_now("sat.m", c_rf0, c_rf1, 2'b00, 1'b1);
        tick();
        cmp("sat.cnt2", bus.stall_cnt, 32'hFFFF_FFFF);
        expect_now("sat.w", c_sw, c_rf1, 2'b00, 1'b0);
        set_src('0, '0, '0, '0);
        tick(); tick(); tick();

        // Asynchronous reset in the middle of a stall
        issue(1'b1, 5'd10, c_tnew_load);
        tick();
        issue(1'b0, '0, '0);
        set_src('0, '0, 5'd10, c_tuse_branch);
        expect_now("rst.pre", c_rf0, c_rf1, 2'b00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("rst.async", c_rf0, c_rf1, 2'b00, 1'b0);
        pop_check();
        cmp("rst.async.cnt", bus.stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_now("rst.after", c_rf0, c_rf1, 2'b00, 1'b0);
        cmp("rst.after.cnt", bus.stall_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fwd_scoreboard
`default_nettype wire
